// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-flop synchronizer, mid-bit 3-sample majority vote,
// optional parity, 1-2 stop bits and sticky error flags behind a rdy/clr_rdy handshake.
module uart_rx_cfg #(
  parameter int CLK_DIV   = 34,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int RX_INV    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX,
  input  logic                 clr_rdy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rdy,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLK_DIV / 2 - 1);
  localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  LAST_DATA = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  LAST_STOP = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t state, state_nxt;

  logic                 line, sync1, rx_s, rx_s_d;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 vote2, vote1, bit_val, tick, start_edge;
  logic                 last_data, last_stop, par_exp, perr, ferr;
  logic                 shift_en, idx_step, idx_clr, par_chk, stop_chk, deliver;

  assign line = (RX_INV != 0) ? ~RX : RX;

  // Flops reset to the idle level so a reset never looks like a start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      rx_s   <= 1'b1;
      rx_s_d <= 1'b1;
    end else begin
      sync1  <= line;
      rx_s   <= sync1;
      rx_s_d <= rx_s;
    end
  end

  assign start_edge = (state == IDLE) && rx_s_d && !rx_s;
  assign tick       = (state != IDLE) && (baud_cnt == '0);
  assign bit_val    = (vote2 & vote1) | (vote2 & rx_s) | (vote1 & rx_s);
  assign last_data  = (bit_idx == LAST_DATA);
  assign last_stop  = (bit_idx == LAST_STOP);
  assign par_exp    = (PARITY == 2) ? ^shreg : ~^shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_edge) state_nxt = START;
      START:   if (tick) state_nxt = bit_val ? IDLE : DATA;
      DATA:    if (tick && last_data) state_nxt = (PARITY != 0) ? PAR : STOP;
      PAR:     if (tick) state_nxt = STOP;
      STOP:    if (tick && last_stop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shift_en = 1'b0;
    idx_step = 1'b0;
    idx_clr  = 1'b0;
    par_chk  = 1'b0;
    stop_chk = 1'b0;
    deliver  = 1'b0;
    if (tick) begin
      case (state)
        START: idx_clr = 1'b1;
        DATA: begin
          shift_en = 1'b1;
          if (last_data) idx_clr = 1'b1;
          else           idx_step = 1'b1;
        end
        PAR: par_chk = 1'b1;
        STOP: begin
          stop_chk = 1'b1;
          if (last_stop) deliver = 1'b1;
          else           idx_step = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The votes at baud_cnt 2 and 1 are combined with the live rx_s at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      vote2    <= 1'b1;
      vote1    <= 1'b1;
      shreg    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      if (start_edge)
        baud_cnt <= BAUD_HALF;
      else if (state != IDLE)
        baud_cnt <= (baud_cnt == '0) ? BAUD_FULL : baud_cnt - 1'b1;
      if (baud_cnt == BAUD_W'(2)) vote2 <= rx_s;
      if (baud_cnt == BAUD_W'(1)) vote1 <= rx_s;
      if (idx_clr)       bit_idx <= '0;
      else if (idx_step) bit_idx <= bit_idx + 1'b1;
      if (shift_en) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
      if (start_edge) begin
        perr <= 1'b0;
        ferr <= 1'b0;
      end else begin
        if (par_chk && (bit_val != par_exp)) perr <= 1'b1;
        if (stop_chk && !bit_val)            ferr <= 1'b1;
      end
    end
  end

  // Completion beats a simultaneous clr_rdy; the flags then describe only the new word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rdy        <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (deliver) begin
      rx_data    <= shreg;
      rdy        <= 1'b1;
      parity_err <= (parity_err & ~clr_rdy) | perr;
      frame_err  <= (frame_err & ~clr_rdy) | ferr | ~bit_val;
      overrun    <= (overrun | rdy) & ~clr_rdy;
    end else if (clr_rdy) begin
      rdy        <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: a default 8N1 receiver (a) and a 7E2 inverted-line
// receiver (b) driven with directed and random frames built from the frame rules.
module tb_uart_rx_cfg;

  localparam int DIV_A = 34;
  localparam int DIV_B = 20;
  localparam int DB_B  = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic line_a = 1'b1, line_b = 1'b1;
  logic rx_a, rx_b;
  logic clr_a = 1'b0, clr_b = 1'b0;
  logic [7:0] data_a;
  logic [6:0] data_b;
  logic rdy_a, pe_a, fe_a, ov_a;
  logic rdy_b, pe_b, fe_b, ov_b;

  assign rx_a = line_a;
  assign rx_b = ~line_b;

  uart_rx_cfg dut_a (
    .clk(clk), .rst_n(rst_n), .RX(rx_a), .clr_rdy(clr_a), .rx_data(data_a),
    .rdy(rdy_a), .parity_err(pe_a), .frame_err(fe_a), .overrun(ov_a)
  );

  uart_rx_cfg #(.CLK_DIV(DIV_B), .DATA_BITS(DB_B), .PARITY(2), .STOP_BITS(2), .RX_INV(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .RX(rx_b), .clr_rdy(clr_b), .rx_data(data_b),
    .rdy(rdy_b), .parity_err(pe_b), .frame_err(fe_b), .overrun(ov_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] data;
    bit         perr;
    bit         ferr;
    bit         ovr;
    int         t_fall;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int lat_a = 326;
  int clr_cyc = -1;
  bit model_rdy[2];
  logic [8:0] model_data[2];
  logic [11:0] prev_a = '0;
  logic [10:0] prev_b = '0;

  always @(posedge clk) cyc++;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    n_checks++;
    if (got >= lo && got <= hi) n_pass++;
    else $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
  endtask

  task automatic score(input int sel, input logic [8:0] d, input bit pe, input bit fe, input bit ov);
    exp_t e;
    string tag = (sel == 0) ? "a" : "b";
    int lat;
    if ((sel == 0 && q_a.size() == 0) || (sel == 1 && q_b.size() == 0)) begin
      n_checks++;
      $display("[TB] FAIL %s_unexpected_word: got 0x%0h, expected no word", tag, d);
      return;
    end
    if (sel == 0) e = q_a.pop_front();
    else          e = q_b.pop_front();
    lat = cyc - e.t_fall;
    check_output($sformatf("%s_data", tag), 32'(d), 32'(e.data));
    check_output($sformatf("%s_parity_err", tag), 32'(pe), 32'(e.perr));
    check_output($sformatf("%s_frame_err", tag), 32'(fe), 32'(e.ferr));
    check_output($sformatf("%s_overrun", tag), 32'(ov), 32'(e.ovr));
    if (sel == 0) begin
      check_range("a_latency", lat, 324, 326);
      lat_a = lat;
    end else begin
      // middle of the final stop bit of an 11-bit frame, plus synchronizer slack
      check_range("b_latency", lat, DIV_B * 10 + DIV_B / 2 - 4, DIV_B * 10 + DIV_B / 2 + 4);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_a = '0;
      prev_b = '0;
    end else begin
      if (rdy_a && (!prev_a[11] || {1'b1, data_a, pe_a, fe_a, ov_a} != prev_a))
        score(0, {1'b0, data_a}, pe_a, fe_a, ov_a);
      if (rdy_b && (!prev_b[10] || {1'b1, data_b, pe_b, fe_b, ov_b} != prev_b))
        score(1, {2'b0, data_b}, pe_b, fe_b, ov_b);
      prev_a = {rdy_a, data_a, pe_a, fe_a, ov_a};
      prev_b = {rdy_b, data_b, pe_b, fe_b, ov_b};
    end
  end

  task automatic set_line(input int sel, input bit v);
    if (sel == 0) line_a = v;
    else          line_b = v;
  endtask

  task automatic idle(input int sel, input int n);
    set_line(sel, 1'b1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_bit(input int sel, input bit v, input bit spike);
    int div = (sel == 0) ? DIV_A : DIV_B;
    set_line(sel, v);
    for (int i = 0; i < div; i++) begin
      @(posedge clk); #1;
      set_line(sel, (spike && i == div / 2) ? !v : v);
      if (clr_cyc >= 0) clr_a = (cyc == clr_cyc);
    end
  endtask

  task automatic pulse_clr(input int sel);
    string tag = (sel == 0) ? "a" : "b";
    if (sel == 0) clr_a = 1'b1;
    else          clr_b = 1'b1;
    @(posedge clk); #1;
    clr_a = 1'b0;
    clr_b = 1'b0;
    model_rdy[sel] = 1'b0;
    check_output($sformatf("%s_rdy_after_clr", tag), 32'(sel == 0 ? rdy_a : rdy_b), 0);
    check_output($sformatf("%s_flags_after_clr", tag),
                 32'(sel == 0 ? {pe_a, fe_a, ov_a} : {pe_b, fe_b, ov_b}), 0);
  endtask

  // Frame = start 0, data LSB first, even parity bit (b only), stop bits (1 for a, 2 for b)
  task automatic apply_stimulus(input int sel, input logic [8:0] data, input bit flip_par,
                                input bit [1:0] stop_zero, input int spike_bit,
                                input int rst_bit, input bit clr_on_done);
    int div = (sel == 0) ? DIV_A : DIV_B;
    int nd = (sel == 0) ? 8 : DB_B;
    int ns = (sel == 0) ? 1 : 2;
    bit fb[$];
    exp_t e;
    logic [8:0] d = data & ((9'd1 << nd) - 9'd1);
    fb.push_back(1'b0);
    for (int i = 0; i < nd; i++) fb.push_back(d[i]);
    if (sel == 1) fb.push_back((($countones(d) % 2) == 1) ^ flip_par);
    for (int i = 0; i < ns; i++) fb.push_back(!stop_zero[i]);
    e.data   = d;
    e.perr   = (sel == 1) && flip_par;
    e.ferr   = (sel == 0) ? stop_zero[0] : (stop_zero != 2'b00);
    e.ovr    = model_rdy[sel] && !clr_on_done;
    e.t_fall = cyc;
    if (clr_on_done) clr_cyc = cyc + lat_a - 1;
    if (rst_bit < 0) begin
      if (sel == 0) q_a.push_back(e);
      else          q_b.push_back(e);
      model_rdy[sel]  = 1'b1;
      model_data[sel] = d;
    end
    foreach (fb[i]) begin
      if (rst_bit >= 0 && i == rst_bit + 1) begin
        set_line(sel, fb[i]);
        repeat (div / 2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #2;
        check_output("rst_b_rdy", 32'(rdy_b), 0);
        check_output("rst_b_data", 32'(data_b), 0);
        check_output("rst_b_flags", 32'({pe_b, fe_b, ov_b}), 0);
        check_output("rst_a_rdy", 32'(rdy_a), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_line(sel, 1'b1);
        model_rdy[0] = 1'b0;
        model_rdy[1] = 1'b0;
        model_data[0] = '0;
        model_data[1] = '0;
        return;
      end
      drive_bit(sel, fb[i], i == spike_bit);
    end
    clr_cyc = -1;
    clr_a = 1'b0;
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: got timeout, expected end of run");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    model_rdy[0] = 1'b0;
    model_rdy[1] = 1'b0;
    model_data[0] = '0;
    model_data[1] = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_a_outputs", 32'({rdy_a, data_a, pe_a, fe_a, ov_a}), 0);
    check_output("reset_b_outputs", 32'({rdy_b, data_b, pe_b, fe_b, ov_b}), 0);
    rst_n = 1'b1;
    idle(0, 5);

    $display("[TB] 8N1 frame 0xA5");
    apply_stimulus(0, 9'hA5, 0, 2'b00, -1, -1, 0);
    idle(0, 10);
    pulse_clr(0);

    $display("[TB] 7E2 parity good and flipped");
    apply_stimulus(1, 9'h3C, 0, 2'b00, -1, -1, 0);
    idle(1, 5);
    pulse_clr(1);
    apply_stimulus(1, 9'h3C, 1, 2'b00, -1, -1, 0);
    idle(1, 5);
    pulse_clr(1);

    $display("[TB] glitch rejection and spike voting");
    line_a = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    idle(0, 2 * DIV_A);
    check_output("glitch_rdy", 32'(rdy_a), 0);
    check_output("glitch_data", 32'(data_a), 32'(model_data[0]));
    check_output("glitch_frame_err", 32'(fe_a), 0);
    apply_stimulus(0, 9'h5C, 0, 2'b00, 3, -1, 0);
    idle(0, 5);
    pulse_clr(0);

    $display("[TB] second stop bit low");
    apply_stimulus(1, 9'h15, 0, 2'b10, -1, -1, 0);
    idle(1, 5);
    check_output("stop_frame_err", 32'(fe_b), 1);
    pulse_clr(1);

    $display("[TB] overrun, then clr_rdy on completion");
    apply_stimulus(0, 9'h11, 0, 2'b00, -1, -1, 0);
    apply_stimulus(0, 9'h22, 0, 2'b00, -1, -1, 0);
    idle(0, 5);
    check_output("ovr_data", 32'(data_a), 32'h22);
    check_output("ovr_flag", 32'(ov_a), 1);
    pulse_clr(0);
    apply_stimulus(0, 9'h11, 0, 2'b00, -1, -1, 0);
    apply_stimulus(0, 9'h22, 0, 2'b00, -1, -1, 1);
    idle(0, 5);
    check_output("clr_done_rdy", 32'(rdy_a), 1);
    check_output("clr_done_overrun", 32'(ov_a), 0);
    pulse_clr(0);

    $display("[TB] break condition");
    apply_stimulus(0, 9'h00, 0, 2'b01, -1, -1, 0);
    line_a = 1'b0;
    repeat (2 * DIV_A) begin @(posedge clk); #1; end
    idle(0, 10);
    pulse_clr(0);

    $display("[TB] reset mid-frame, then clean frame");
    apply_stimulus(1, 9'h2B, 0, 2'b01, -1, -1, 0);
    idle(1, 4);
    apply_stimulus(1, 9'hFF, 0, 2'b00, -1, 4, 0);
    idle(1, 3 * DIV_B);
    apply_stimulus(1, 9'h5A, 0, 2'b00, -1, -1, 0);
    idle(1, 5);
    pulse_clr(1);

    $display("[TB] random frames");
    for (int n = 0; n < 6; n++) begin
      apply_stimulus(0, 9'($urandom_range(0, 255)), 0, 2'b00,
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : -1, -1, 0);
      idle(0, $urandom_range(2, 30));
      pulse_clr(0);
    end
    for (int n = 0; n < 8; n++) begin
      apply_stimulus(1, 9'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00, -1, -1, 0);
      idle(1, $urandom_range(3, 20));
      pulse_clr(1);
    end

    idle(0, 50);
    check_output("a_pending_words", 32'(q_a.size()), 0);
    check_output("b_pending_words", 32'(q_b.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
